// File: rtl/uart_word_tx.sv
// 8N1 UART transmitter: each accepted AXI-Stream word is sent as
// ceil(WORD_WIDTH/8) byte frames, least-significant byte first.
module uart_word_tx #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [15:0]           prescale,
  output logic                  txd,
  output logic                  tx_busy
);

  localparam int NBYTES = (WORD_WIDTH + 7) / 8;
  localparam int SHW    = NBYTES * 8;
  localparam int IDXW   = $clog2(NBYTES + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q;
  logic [SHW-1:0]  shreg_q;
  logic [15:0]     p_q;
  logic [18:0]     pcnt_q;
  logic [2:0]      bit_q;
  logic [IDXW-1:0] idx_q;
  logic            txd_q;

  logic            bit_done_s;
  logic [7:0]      cur_byte_s;

  // The current byte always sits in the low 8 bits; the word shifts down per byte.
  assign cur_byte_s = shreg_q[7:0];
  assign bit_done_s = (pcnt_q == ({p_q, 3'b000} - 19'd1));

  assign txd           = txd_q;
  assign s_axis_tready = (state_q == IDLE);
  assign tx_busy       = (state_q != IDLE);

  // Frame sequencer: start bit, 8 data bits, stop bit, repeated per byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      p_q     <= 16'd0;
      pcnt_q  <= 19'd0;
      bit_q   <= 3'd0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (s_axis_tvalid) begin
            shreg_q <= SHW'(s_axis_tdata);
            p_q     <= (prescale == 16'd0) ? 16'd1 : prescale;
            idx_q   <= '0;
            pcnt_q  <= 19'd0;
            bit_q   <= 3'd0;
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_done_s) begin
            pcnt_q  <= 19'd0;
            bit_q   <= 3'd0;
            txd_q   <= cur_byte_s[0];
            state_q <= DATA;
          end else begin
            pcnt_q <= pcnt_q + 19'd1;
          end
        end
        DATA: begin
          if (bit_done_s) begin
            pcnt_q <= 19'd0;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              txd_q <= cur_byte_s[bit_q + 3'd1];
            end
          end else begin
            pcnt_q <= pcnt_q + 19'd1;
          end
        end
        STOP: begin
          if (bit_done_s) begin
            pcnt_q <= 19'd0;
            if (idx_q < LAST_IDX) begin
              idx_q   <= idx_q + {{(IDXW-1){1'b0}}, 1'b1};
              shreg_q <= shreg_q >> 4'd8;
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            pcnt_q <= pcnt_q + 19'd1;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: three instances (16/12/8-bit words) checked every cycle
// against a frame-arithmetic model, plus a UART decoder and literal expectations.
module tb_uart_word_tx;

  logic        clk;
  logic        rst_s   [3];
  logic        valid_s [3];
  logic [15:0] tdata_s [3];
  logic [15:0] presc_s [3];
  logic        ready_s [3];
  logic        txd_s   [3];
  logic        busy_s  [3];

  int n_chk;
  int n_fail;
  bit chk_en;

  uart_word_tx #(.WORD_WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst_s[0]), .s_axis_tdata(tdata_s[0]), .s_axis_tvalid(valid_s[0]),
    .s_axis_tready(ready_s[0]), .prescale(presc_s[0]), .txd(txd_s[0]), .tx_busy(busy_s[0]));
  uart_word_tx #(.WORD_WIDTH(12)) u_w12 (
    .clk(clk), .rst(rst_s[1]), .s_axis_tdata(tdata_s[1][11:0]), .s_axis_tvalid(valid_s[1]),
    .s_axis_tready(ready_s[1]), .prescale(presc_s[1]), .txd(txd_s[1]), .tx_busy(busy_s[1]));
  uart_word_tx #(.WORD_WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst_s[2]), .s_axis_tdata(tdata_s[2][7:0]), .s_axis_tvalid(valid_s[2]),
    .s_axis_tready(ready_s[2]), .prescale(presc_s[2]), .txd(txd_s[2]), .tx_busy(busy_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid(input int i);
    case (i)
      0: return 16;
      1: return 12;
      default: return 8;
    endcase
  endfunction

  function automatic int nby(input int i);
    return (wid(i) + 7) / 8;
  endfunction

  // Expected line level at cycle 'off' of a word: frame = 80*p cycles, 10 slots of 8*p.
  function automatic logic exp_txd(input logic [15:0] data, input int w, input int p, input int off);
    int f, slot, b;
    f    = off / (80 * p);
    slot = (off % (80 * p)) / (8 * p);
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    b = 8 * f + slot - 1;
    return (b < w) ? data[b] : 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: active word, cycle offset within it, latched data and bit divider.
  bit          m_act  [3];
  int          m_off  [3];
  logic [15:0] m_data [3];
  int          m_p    [3];
  int          cyc;
  int          hs_cnt [3];
  int          hs_last[3];
  int          hs_prev[3];

  // Model advance and handshake bookkeeping on each rising edge.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (valid_s[i] === 1'b1 && ready_s[i] === 1'b1 && rst_s[i] === 1'b0) begin
        hs_cnt[i]++;
        hs_prev[i] = hs_last[i];
        hs_last[i] = cyc;
      end
      if (rst_s[i]) begin
        m_act[i] = 1'b0;
      end else if (m_act[i]) begin
        m_off[i]++;
        if (m_off[i] == nby(i) * 80 * m_p[i]) m_act[i] = 1'b0;
      end else if (valid_s[i]) begin
        m_act[i]  = 1'b1;
        m_off[i]  = 0;
        m_data[i] = tdata_s[i];
        m_p[i]    = (presc_s[i] == 16'd0) ? 1 : int'(presc_s[i]);
      end
    end
  end

  int busy_cnt[3];

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        if (m_act[i]) begin
          chk($sformatf("txd%0d", i), 32'(txd_s[i]),
              32'(exp_txd(m_data[i], wid(i), m_p[i], m_off[i])));
        end else begin
          chk($sformatf("txd%0d", i), 32'(txd_s[i]), 32'd1);
        end
        chk($sformatf("busy%0d", i), 32'(busy_s[i]), 32'(m_act[i]));
        chk($sformatf("ready%0d", i), 32'(ready_s[i]), 32'(!m_act[i]));
        if (busy_s[i] === 1'b1) busy_cnt[i]++;
      end
    end
  end

  // Independent UART decoder sampling mid-bit with a bench-chosen divider.
  int         rx_st  [3];
  int         rx_cnt [3];
  logic [7:0] rx_b   [3];
  int         rx_p   [3];
  int         rx_ferr;
  int         rx_q[$];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_s[i] !== 1'b0) begin
        rx_st[i] = 0;
      end else if (rx_st[i] == 0) begin
        if (txd_s[i] === 1'b0) begin
          rx_st[i]  = 1;
          rx_cnt[i] = 0;
        end
      end else begin
        rx_cnt[i]++;
        if (rx_cnt[i] % (8 * rx_p[i]) == 4 * rx_p[i]) begin
          int k;
          k = rx_cnt[i] / (8 * rx_p[i]);
          if (k == 0) begin
            if (txd_s[i] !== 1'b0) rx_ferr++;
          end else if (k <= 8) begin
            rx_b[i][k-1] = txd_s[i];
          end else begin
            if (txd_s[i] !== 1'b1) rx_ferr++;
            rx_q.push_back(i * 256 + int'(rx_b[i]));
            rx_st[i] = 0;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_byte(input string name, input int i, input int b);
    if (rx_q.size() == 0) begin
      chk(name, 32'hFFFF_FFFF, 32'(i * 256 + b));
    end else begin
      chk(name, 32'(rx_q.pop_front()), 32'(i * 256 + b));
    end
  endtask

  task automatic clear_stats(input int i);
    busy_cnt[i] = 0;
    hs_cnt[i]   = 0;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    cyc     = 0;
    rx_ferr = 0;
    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b1; valid_s[i] = 1'b0; tdata_s[i] = 16'h0; presc_s[i] = 16'd1;
      m_act[i] = 1'b0; m_off[i] = 0; m_data[i] = 16'h0; m_p[i] = 1;
      rx_st[i] = 0; rx_cnt[i] = 0; rx_b[i] = 8'h0; rx_p[i] = 1;
      busy_cnt[i] = 0; hs_cnt[i] = 0; hs_last[i] = 0; hs_prev[i] = 0;
    end
    tick(3);
    for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;
    chk_en = 1'b1;
    chk("reset_txd", 32'(txd_s[0]), 32'd1);
    chk("reset_busy", 32'(busy_s[0]), 32'd0);
    chk("reset_ready", 32'(ready_s[0]), 32'd1);

    // Single 16-bit word at prescale 1.
    clear_stats(0);
    rx_p[0] = 1; presc_s[0] = 16'd1;
    tdata_s[0] = 16'hA55A; valid_s[0] = 1'b1;
    tick(1);
    valid_s[0] = 1'b0;
    tick(170);
    expect_byte("single_b0", 0, 8'h5A);
    expect_byte("single_b1", 0, 8'hA5);
    chk("single_busy_cycles", 32'(busy_cnt[0]), 32'd160);
    chk("single_ready_after", 32'(ready_s[0]), 32'd1);
    chk("single_hs_count", 32'(hs_cnt[0]), 32'd1);

    // 12-bit word padded to two bytes at prescale 2.
    clear_stats(1);
    rx_p[1] = 2; presc_s[1] = 16'd2;
    tdata_s[1] = 16'h0FFF; valid_s[1] = 1'b1;
    tick(1);
    valid_s[1] = 1'b0;
    tick(330);
    expect_byte("pad_b0", 1, 8'hFF);
    expect_byte("pad_b1", 1, 8'h0F);
    chk("pad_busy_cycles", 32'(busy_cnt[1]), 32'd320);

    // Back-to-back 8-bit words with valid held high.
    clear_stats(2);
    rx_p[2] = 1; presc_s[2] = 16'd1;
    tdata_s[2] = 16'h0001; valid_s[2] = 1'b1;
    tick(1);
    tdata_s[2] = 16'h0080;
    for (int n = 0; n < 300 && hs_cnt[2] < 2; n++) tick(1);
    valid_s[2] = 1'b0;
    chk("b2b_hs_reached", 32'(hs_cnt[2]), 32'd2);
    chk("b2b_hs_spacing", 32'(hs_last[2] - hs_prev[2]), 32'd81);
    tick(100);
    chk("b2b_hs_count", 32'(hs_cnt[2]), 32'd2);
    expect_byte("b2b_b0", 2, 8'h01);
    expect_byte("b2b_b1", 2, 8'h80);
    chk("b2b_busy_cycles", 32'(busy_cnt[2]), 32'd160);

    // Reset during data bit 3 of byte 0, then a clean word.
    clear_stats(0);
    tdata_s[0] = 16'h00FF; valid_s[0] = 1'b1;
    tick(1);
    valid_s[0] = 1'b0;
    tick(34);
    chk("rst_mid_busy_before", 32'(busy_s[0]), 32'd1);
    rst_s[0] = 1'b1;
    tick(1);
    rst_s[0] = 1'b0;
    chk("rst_txd", 32'(txd_s[0]), 32'd1);
    chk("rst_busy", 32'(busy_s[0]), 32'd0);
    chk("rst_ready", 32'(ready_s[0]), 32'd1);
    chk("rst_no_partial_byte", 32'(rx_q.size()), 32'd0);
    busy_cnt[0] = 0;
    tdata_s[0] = 16'h1234; valid_s[0] = 1'b1;
    tick(1);
    valid_s[0] = 1'b0;
    tick(170);
    expect_byte("rst_new_b0", 0, 8'h34);
    expect_byte("rst_new_b1", 0, 8'h12);
    chk("rst_new_busy_cycles", 32'(busy_cnt[0]), 32'd160);

    // Inputs disturbed while busy; prescale 0 acts as 1.
    clear_stats(0);
    presc_s[0] = 16'd0;
    tdata_s[0] = 16'h5AC3; valid_s[0] = 1'b1;
    tick(1);
    valid_s[0] = 1'b0;
    tick(20);
    presc_s[0] = 16'd5;
    for (int n = 0; n < 110; n++) begin
      valid_s[0] = ~valid_s[0];
      tdata_s[0] = 16'($urandom);
      tick(1);
    end
    valid_s[0] = 1'b0;
    tick(40);
    chk("stable_hs_count", 32'(hs_cnt[0]), 32'd1);
    expect_byte("stable_b0", 0, 8'hC3);
    expect_byte("stable_b1", 0, 8'h5A);
    chk("stable_busy_cycles", 32'(busy_cnt[0]), 32'd160);

    chk("framing_errors", 32'(rx_ferr), 32'd0);
    chk("leftover_bytes", 32'(rx_q.size()), 32'd0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
